// File: rtl/attitude_encoder_if.sv
// ---------------------------------------------------------------------------
// attitude_encoder_if
// Purpose : sample-in / attitude-out signal bundle for attitude_encoder.
// Signals : i_Valid     - sample pair present on i_Roll / i_Pitch
//           i_Roll      - signed roll sample, DATA_W bits
//           i_Pitch     - signed pitch sample, DATA_W bits
//           o_Ready     - encoder accepts a sample this cycle
//           o_Attitude  - {sgn(roll), sgn(pitch), over(roll), over(pitch)}
//           o_Att_Valid - one-cycle pulse when o_Attitude is updated
// Modports: master (sample producer / attitude consumer), slave (encoder)
// ---------------------------------------------------------------------------
interface attitude_encoder_if #(
  parameter int DATA_W = 12
);
  logic                     i_Valid;
  logic signed [DATA_W-1:0] i_Roll;
  logic signed [DATA_W-1:0] i_Pitch;
  logic                     o_Ready;
  logic [3:0]               o_Attitude;
  logic                     o_Att_Valid;

  modport master (
    output i_Valid, i_Roll, i_Pitch,
    input  o_Ready, o_Attitude, o_Att_Valid
  );

  modport slave (
    input  i_Valid, i_Roll, i_Pitch,
    output o_Ready, o_Attitude, o_Att_Valid
  );
endinterface

// File: rtl/attitude_encoder.sv
// ---------------------------------------------------------------------------
// attitude_encoder
// Purpose : averages 2^AVG_LOG2 roll/pitch sample pairs per window and
//           encodes the window averages as sign and over-threshold flags.
// Ports   : i_Clk   - clock, all state on rising edge
//           i_Rst_L - asynchronous active-low reset
//           bus     - attitude_encoder_if.slave (i_Valid, i_Roll, i_Pitch,
//                     o_Ready, o_Attitude, o_Att_Valid)
// Config  : ATT_ENC_HYST_EN - when defined, over flags use a hysteresis band
//           (set above THRESH, clear below THRESH-HYST); otherwise each
//           window is compared against THRESH with no history.
//
// state | meaning
// ACCUM | accepting samples, o_Ready high
// EVAL  | one cycle: window averages encoded, o_Ready low
// ---------------------------------------------------------------------------
module attitude_encoder #(
  parameter int DATA_W   = 12,
  parameter int AVG_LOG2 = 2,
  parameter int THRESH   = 200,
  parameter int HYST     = 32
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  attitude_encoder_if.slave  bus
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int MAG_W = DATA_W + 1;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  localparam logic [CNT_W-1:0] C_LAST   = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [MAG_W-1:0] C_THRESH = MAG_W'(THRESH);
`ifdef ATT_ENC_HYST_EN
  localparam logic [MAG_W-1:0] C_CLEAR  = MAG_W'(THRESH - HYST);
`endif

  if (THRESH <= 0 || THRESH >= (1 << (DATA_W - 1)) || HYST < 0 || HYST >= THRESH)
  begin : g_bad_param
    $error("attitude_encoder: THRESH/HYST out of range");
  end

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    EVAL  = 1'b1
  } state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic signed [ACC_W-1:0] r_acc_roll;
  logic signed [ACC_W-1:0] r_acc_pitch;
  logic [3:0]              r_attitude;
  logic                    r_att_valid;

  logic                    w_ready;
  logic                    w_accept;
  logic [DATA_W-1:0]       w_avg_roll;
  logic [DATA_W-1:0]       w_avg_pitch;
  logic [MAG_W-1:0]        w_mag_roll;
  logic [MAG_W-1:0]        w_mag_pitch;
  logic                    w_over_roll;
  logic                    w_over_pitch;

  // Magnitude is one bit wider than the sample so the most negative value
  // maps to +2^(DATA_W-1) instead of wrapping.
  function automatic logic [MAG_W-1:0] f_mag(input logic [DATA_W-1:0] a);
    logic [MAG_W-1:0] ext;
    ext = {a[DATA_W-1], a};
    return a[DATA_W-1] ? (~ext + 1'b1) : ext;
  endfunction

  assign w_ready  = (r_state == ACCUM);
  assign w_accept = bus.i_Valid & w_ready;

  // Dropping the low AVG_LOG2 bits of the accumulator is the floor
  // arithmetic shift; the remaining width is exactly DATA_W.
  assign w_avg_roll  = r_acc_roll[ACC_W-1:AVG_LOG2];
  assign w_avg_pitch = r_acc_pitch[ACC_W-1:AVG_LOG2];
  assign w_mag_roll  = f_mag(w_avg_roll);
  assign w_mag_pitch = f_mag(w_avg_pitch);

  always_comb begin
    w_over_roll  = 1'b0;
    w_over_pitch = 1'b0;
`ifdef ATT_ENC_HYST_EN
    w_over_roll  = r_attitude[1] ? !(w_mag_roll < C_CLEAR)  : (w_mag_roll > C_THRESH);
    w_over_pitch = r_attitude[0] ? !(w_mag_pitch < C_CLEAR) : (w_mag_pitch > C_THRESH);
`else
    w_over_roll  = (w_mag_roll > C_THRESH);
    w_over_pitch = (w_mag_pitch > C_THRESH);
`endif
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state     <= ACCUM;
      r_cnt       <= '0;
      r_acc_roll  <= '0;
      r_acc_pitch <= '0;
      r_attitude  <= 4'b0000;
      r_att_valid <= 1'b0;
    end else begin
      r_att_valid <= 1'b0;
      case (r_state)
        ACCUM: begin
          if (w_accept) begin
            r_acc_roll  <= r_acc_roll  + ACC_W'($signed(bus.i_Roll));
            r_acc_pitch <= r_acc_pitch + ACC_W'($signed(bus.i_Pitch));
            if (r_cnt == C_LAST) begin
              r_cnt   <= '0;
              r_state <= EVAL;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        EVAL: begin
          r_attitude  <= {w_avg_roll[DATA_W-1], w_avg_pitch[DATA_W-1],
                          w_over_roll, w_over_pitch};
          r_att_valid <= 1'b1;
          r_acc_roll  <= '0;
          r_acc_pitch <= '0;
          r_state     <= ACCUM;
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  assign bus.o_Ready     = w_ready;
  assign bus.o_Attitude  = r_attitude;
  assign bus.o_Att_Valid = r_att_valid;

endmodule

// File: tb/tb_attitude_encoder.sv
// ---------------------------------------------------------------------------
// tb_attitude_encoder
// Directed windows followed by randomized windows, each compared against a
// window-level model: floor average of the accepted samples, absolute value,
// and the over-flag rule applied per axis.
// ---------------------------------------------------------------------------
module tb_attitude_encoder;
  localparam int DATA_W   = 12;
  localparam int AVG_LOG2 = 2;
  localparam int THRESH   = 200;
  localparam int HYST     = 32;
  localparam int NWIN     = 1 << AVG_LOG2;

  logic clk;
  logic rst_n;

  attitude_encoder_if #(.DATA_W(DATA_W)) bus ();

  attitude_encoder #(
    .DATA_W  (DATA_W),
    .AVG_LOG2(AVG_LOG2),
    .THRESH  (THRESH),
    .HYST    (HYST)
  ) dut (
    .i_Clk  (clk),
    .i_Rst_L(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int win_r [NWIN];
  int win_p [NWIN];

  bit         m_ovr;
  bit         m_ovp;
  logic [3:0] m_att;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int floor_avg(input int s);
    if (s >= 0) return s / NWIN;
    return -((-s + NWIN - 1) / NWIN);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic bit over_next(input int mag, input bit prev);
`ifdef ATT_ENC_HYST_EN
    if (prev) return (mag >= THRESH - HYST);
    return (mag > THRESH);
`else
    return (mag > THRESH);
`endif
  endfunction

  // One full window: NWIN accepted samples (optionally with idle gaps), the
  // EVAL cycle, the result pulse, and one hold cycle.
  task automatic run_window(input bit gaps, input bit hold999, input int exp_const);
    int sum_r;
    int sum_p;
    int avg_r;
    int avg_p;
    sum_r = 0;
    sum_p = 0;
    for (int k = 0; k < NWIN; k++) begin
      if (gaps) begin
        int idle;
        idle = int'($urandom_range(0, 2));
        for (int g = 0; g < idle; g++) begin
          @(negedge clk);
          check("rdy_idle", 32'(bus.o_Ready), 32'd1);
          bus.i_Valid = 1'b0;
          bus.i_Roll  = DATA_W'($urandom);
          bus.i_Pitch = DATA_W'($urandom);
        end
      end
      @(negedge clk);
      check("rdy_acc", 32'(bus.o_Ready), 32'd1);
      check("pulse_idle", 32'(bus.o_Att_Valid), 32'd0);
      bus.i_Valid = 1'b1;
      bus.i_Roll  = DATA_W'(win_r[k]);
      bus.i_Pitch = DATA_W'(win_p[k]);
      sum_r += win_r[k];
      sum_p += win_p[k];
    end
    @(negedge clk);
    check("rdy_eval", 32'(bus.o_Ready), 32'd0);
    check("pulse_early", 32'(bus.o_Att_Valid), 32'd0);
    bus.i_Valid = hold999;
    bus.i_Roll  = DATA_W'(999);
    bus.i_Pitch = DATA_W'(999);
    avg_r = floor_avg(sum_r);
    avg_p = floor_avg(sum_p);
    m_ovr = over_next(iabs(avg_r), m_ovr);
    m_ovp = over_next(iabs(avg_p), m_ovp);
    m_att = {avg_r < 0, avg_p < 0, m_ovr, m_ovp};
    @(negedge clk);
    check("pulse", 32'(bus.o_Att_Valid), 32'd1);
    check("attitude", 32'(bus.o_Attitude), 32'(m_att));
    if (exp_const >= 0) check("att_directed", 32'(bus.o_Attitude), 32'(exp_const));
    check("rdy_back", 32'(bus.o_Ready), 32'd1);
    bus.i_Valid = 1'b0;
    @(negedge clk);
    check("pulse_end", 32'(bus.o_Att_Valid), 32'd0);
    check("att_hold", 32'(bus.o_Attitude), 32'(m_att));
  endtask

  task automatic fill_const(input int r, input int p);
    for (int k = 0; k < NWIN; k++) begin
      win_r[k] = r;
      win_p[k] = p;
    end
  endtask

  function automatic int rand_sample(input int mode);
    int v;
    case (mode)
      0:       v = int'($urandom_range(0, 4095)) - 2048;
      1:       v = int'($urandom_range(140, 260)) * (($urandom_range(0, 1) == 0) ? 1 : -1);
      default: v = ($urandom_range(0, 1) == 0) ? -2048 : 2047;
    endcase
    return v;
  endfunction

  task automatic fill_rand();
    int mode;
    mode = int'($urandom_range(0, 2));
    for (int k = 0; k < NWIN; k++) begin
      win_r[k] = rand_sample(mode);
      win_p[k] = rand_sample(mode);
    end
  endtask

  initial begin
    m_ovr = 1'b0;
    m_ovp = 1'b0;
    m_att = 4'b0000;
    rst_n       = 1'b0;
    bus.i_Valid = 1'b0;
    bus.i_Roll  = '0;
    bus.i_Pitch = '0;
    repeat (2) @(negedge clk);
    check("rst_att", 32'(bus.o_Attitude), 32'd0);
    check("rst_pulse", 32'(bus.o_Att_Valid), 32'd0);
    check("rst_rdy", 32'(bus.o_Ready), 32'd1);
    rst_n = 1'b1;

    fill_const(0, 0);
    run_window(1'b0, 1'b0, 4'b0000);

    fill_const(300, -300);
    run_window(1'b0, 1'b0, 4'b0111);

    win_r = '{100, 200, 300, 400};
    win_p = '{-2048, -2048, -2048, -2048};
    run_window(1'b0, 1'b0, 4'b0111);

    fill_const(180, 0);
`ifdef ATT_ENC_HYST_EN
    run_window(1'b0, 1'b0, 4'b0010);
`else
    run_window(1'b0, 1'b0, 4'b0000);
`endif
    fill_const(160, 0);
    run_window(1'b0, 1'b0, 4'b0000);

    fill_const(250, 250);
    run_window(1'b0, 1'b1, 4'b0011);
    fill_const(-10, -10);
    run_window(1'b0, 1'b0, 4'b1100);

    for (int w = 0; w < 16; w++) begin
      fill_rand();
      run_window(w[0], w[1], -1);
    end

    fill_const(300, -300);
    run_window(1'b0, 1'b0, 4'b0111);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.i_Valid = 1'b1;
      bus.i_Roll  = DATA_W'(500);
      bus.i_Pitch = DATA_W'(0);
    end
    @(negedge clk);
    bus.i_Valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_att", 32'(bus.o_Attitude), 32'd0);
    check("async_pulse", 32'(bus.o_Att_Valid), 32'd0);
    check("async_rdy", 32'(bus.o_Ready), 32'd1);
    m_ovr = 1'b0;
    m_ovp = 1'b0;
    m_att = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    fill_const(0, 0);
    run_window(1'b0, 1'b0, 4'b0000);

    for (int w = 0; w < 4; w++) begin
      fill_rand();
      run_window(1'b1, 1'b0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
